// File: rtl/sr_display_decoder_if.sv
// ----------------------------------------------------------------------------
// sr_display_decoder_if
// Result bus of the 7-segment display-link decoder: one decoded frame per
// valid/ready transfer, plus a one-cycle overrun pulse.
//   o_data        decoded absolute value
//   o_data_is_neg a minus sign was present
//   o_error       frame was the "Err" pattern
//   o_frame_err   malformed frame
//   o_valid       decoded frame available
//   i_ready       consumer accepts the frame
//   o_overrun     one-cycle pulse, a frame was dropped
// master = decoder side, slave = consumer side.
// ----------------------------------------------------------------------------
interface sr_display_decoder_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_data_is_neg;
   logic                  o_error;
   logic                  o_frame_err;
   logic                  o_valid;
   logic                  i_ready;
   logic                  o_overrun;

   modport master (
      output o_data,
      output o_data_is_neg,
      output o_error,
      output o_frame_err,
      output o_valid,
      input  i_ready,
      output o_overrun
   );

   modport slave (
      input  o_data,
      input  o_data_is_neg,
      input  o_error,
      input  o_frame_err,
      input  o_valid,
      output i_ready,
      input  o_overrun
   );
endinterface

// File: rtl/sr_display_decoder.sv
// ----------------------------------------------------------------------------
// sr_display_decoder
// Oversampling receiver for the 7-segment shift-register display link.
// Captures each latched frame of NUM_7_SEG_DISPLAYS*7 segment bits, decodes
// it back into a hex value with negative / "Err" / malformed flags and offers
// the result on a valid/ready bus.
// Ports:
//   clk, rst_n           receiver clock, synchronous active-low reset
//   i_sr_data            serial segment data (asynchronous)
//   i_sr_clk             shift clock, bit taken on rising edge (asynchronous)
//   i_sr_latch           frame latch, frame ends on rising edge (asynchronous)
//   bus                  result bus (sr_display_decoder_if.master)
// Build option:
//   SR_DECODER_STRICT_EN defined   -> malformed-frame checks (bit count,
//                                     illegal patterns, stray R, misplaced
//                                     minus) drive o_frame_err.
//   SR_DECODER_STRICT_EN undefined -> o_frame_err tied 0, offending digits
//                                     decode silently to 0.
// ----------------------------------------------------------------------------
module sr_display_decoder #(
   parameter int unsigned DATA_WIDTH         = 16,
   parameter int unsigned NUM_7_SEG_DISPLAYS = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_sr_data,
   input  logic                 i_sr_clk,
   input  logic                 i_sr_latch,
   sr_display_decoder_if.master bus
);

   localparam int unsigned W        = NUM_7_SEG_DISPLAYS * 7;
   localparam int unsigned NUM_NIB  = DATA_WIDTH / 4;
   localparam int unsigned NUM_USED = (NUM_NIB < NUM_7_SEG_DISPLAYS) ? NUM_NIB : NUM_7_SEG_DISPLAYS;
`ifdef SR_DECODER_STRICT_EN
   localparam int unsigned      CNT_W    = $clog2(W + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
`endif

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b0000001;
   localparam logic [6:0] SEG_R     = 7'b0000101;
   localparam logic [6:0] SEG_E     = 7'b1001111;

   typedef enum logic [0:0] {
      ST_SHIFT  = 1'b0,
      ST_DECODE = 1'b1
   } state_t;

   // {hit, nibble}; nibble is 0 when the pattern is not a hex digit
   function automatic logic [4:0] hex_lookup(input logic [6:0] seg);
      case (seg)
         7'b1111110: hex_lookup = 5'h10;
         7'b0110000: hex_lookup = 5'h11;
         7'b1101101: hex_lookup = 5'h12;
         7'b1111001: hex_lookup = 5'h13;
         7'b0110011: hex_lookup = 5'h14;
         7'b1011011: hex_lookup = 5'h15;
         7'b1011111: hex_lookup = 5'h16;
         7'b1110000: hex_lookup = 5'h17;
         7'b1111111: hex_lookup = 5'h18;
         7'b1111011: hex_lookup = 5'h19;
         7'b1110111: hex_lookup = 5'h1A;
         7'b0011111: hex_lookup = 5'h1B;
         7'b1001110: hex_lookup = 5'h1C;
         7'b0111101: hex_lookup = 5'h1D;
         7'b1001111: hex_lookup = 5'h1E;
         7'b1000111: hex_lookup = 5'h1F;
         default:    hex_lookup = 5'h00;
      endcase
   endfunction

   state_t                r_state;
   logic                  r_data_s1, r_data_s2;
   logic                  r_clk_s1, r_clk_s2, r_clk_d;
   logic                  r_latch_s1, r_latch_s2, r_latch_d;
   logic [W-1:0]          r_shreg;
   logic [W-1:0]          r_frame;
`ifdef SR_DECODER_STRICT_EN
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      r_frame_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_bad;
`endif
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_neg;
   logic                  r_error;
   logic                  r_frame_err;
   logic                  r_valid;
   logic                  r_overrun;

   logic                  w_shift_ev;
   logic                  w_latch_ev;
   logic [W-1:0]          w_shreg_nxt;
   logic                  w_out_free;
   int unsigned           w_top;
   logic                  w_is_err_frame;
   logic                  w_neg;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_frame_err;

   assign w_shift_ev  = r_clk_s2 & ~r_clk_d;
   assign w_latch_ev  = r_latch_s2 & ~r_latch_d;
   assign w_shreg_nxt = w_shift_ev ? {r_shreg[W-2:0], r_data_s2} : r_shreg;
   assign w_out_free  = ~r_valid | bus.i_ready;

`ifdef SR_DECODER_STRICT_EN
   // Saturating bit count including this cycle's shift
   assign w_cnt_nxt = (w_shift_ev && (r_bit_cnt != CNT_MAX)) ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
`endif

   // Index of the highest non-blank display (0 when all blank)
   always_comb begin
      w_top = 0;
      for (int unsigned k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
         if (r_frame[k*7 +: 7] != SEG_BLANK) w_top = k;
      end
   end

   // "Err" occupies displays 2..0 with everything above blank
   always_comb begin
      w_is_err_frame = (r_frame[14 +: 7] == SEG_E) && (r_frame[7 +: 7] == SEG_R) &&
                       (r_frame[0 +: 7] == SEG_R);
      for (int unsigned k = 3; k < NUM_7_SEG_DISPLAYS; k++) begin
         if (r_frame[k*7 +: 7] != SEG_BLANK) w_is_err_frame = 1'b0;
      end
   end

   // Per-display classification and nibble assembly
   always_comb begin : p_classify
      logic [4:0] v_hex;
      logic [6:0] v_seg;
      v_hex  = 5'h00;
      v_seg  = SEG_BLANK;
      w_neg  = 1'b0;
      w_data = '0;
`ifdef SR_DECODER_STRICT_EN
      w_bad  = 1'b0;
`endif
      for (int unsigned k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
         v_seg = r_frame[k*7 +: 7];
         v_hex = hex_lookup(v_seg);
         if (v_hex[4]) begin
            // plain digit, nothing to flag
         end else if (v_seg == SEG_MINUS) begin
            if (k == w_top) w_neg = 1'b1;
`ifdef SR_DECODER_STRICT_EN
            else w_bad = 1'b1;
         end else if (v_seg == SEG_R) begin
            if (!w_is_err_frame) w_bad = 1'b1;
         end else if (v_seg != SEG_BLANK) begin
            w_bad = 1'b1;
`endif
         end
      end
      // Non-hex patterns already map to nibble 0
      for (int unsigned k = 0; k < NUM_USED; k++) begin
         v_hex = hex_lookup(r_frame[k*7 +: 7]);
         w_data[k*4 +: 4] = v_hex[3:0];
      end
   end

`ifdef SR_DECODER_STRICT_EN
   assign w_frame_err = w_bad | (r_frame_cnt != CNT_FULL);
`else
   assign w_frame_err = 1'b0;
`endif

   // Synchronizers, shift register, frame FSM and registered result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_SHIFT;
         r_data_s1   <= 1'b0;
         r_data_s2   <= 1'b0;
         r_clk_s1    <= 1'b0;
         r_clk_s2    <= 1'b0;
         r_clk_d     <= 1'b0;
         r_latch_s1  <= 1'b0;
         r_latch_s2  <= 1'b0;
         r_latch_d   <= 1'b0;
         r_shreg     <= '0;
         r_frame     <= '0;
`ifdef SR_DECODER_STRICT_EN
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
`endif
         r_data      <= '0;
         r_neg       <= 1'b0;
         r_error     <= 1'b0;
         r_frame_err <= 1'b0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_data_s1  <= i_sr_data;
         r_data_s2  <= r_data_s1;
         r_clk_s1   <= i_sr_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_d    <= r_clk_s2;
         r_latch_s1 <= i_sr_latch;
         r_latch_s2 <= r_latch_s1;
         r_latch_d  <= r_latch_s2;

         r_shreg   <= w_shreg_nxt;
         r_overrun <= 1'b0;
`ifdef SR_DECODER_STRICT_EN
         r_bit_cnt <= w_cnt_nxt;
`endif
         if (r_valid && bus.i_ready) r_valid <= 1'b0;

         case (r_state)
            ST_SHIFT: begin
               if (w_latch_ev) begin
                  // Snapshot includes a bit shifted in during this same cycle
                  r_frame     <= w_shreg_nxt;
`ifdef SR_DECODER_STRICT_EN
                  r_frame_cnt <= w_cnt_nxt;
                  r_bit_cnt   <= '0;
`endif
                  r_state     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               // Latch events here are ignored; the next frame's count exposes them
               if (w_out_free) begin
                  r_valid     <= 1'b1;
                  r_data      <= w_is_err_frame ? '0 : w_data;
                  r_neg       <= ~w_is_err_frame & w_neg;
                  r_error     <= w_is_err_frame;
                  r_frame_err <= w_frame_err;
               end else begin
                  r_overrun   <= 1'b1;
               end
               r_state <= ST_SHIFT;
            end
            default: r_state <= ST_SHIFT;
         endcase
      end
   end

   assign bus.o_data        = r_data;
   assign bus.o_data_is_neg = r_neg;
   assign bus.o_error       = r_error;
   assign bus.o_frame_err   = r_frame_err;
   assign bus.o_valid       = r_valid;
   assign bus.o_overrun     = r_overrun;

endmodule
